// File: rtl/cplx_par2ser_buf.sv
// Parallel-load, serial-out buffer for complex samples: captures DEPTH re/im lanes
// in one cycle and unloads one lane per beat under valid/ready, optionally bit-reversed.
module cplx_par2ser_buf #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   brev,
  input  logic [DEPTH*WIDTH-1:0] din_re,
  input  logic [DEPTH*WIDTH-1:0] din_im,
  output logic                   load_ready,
  output logic                   load_drop,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [WIDTH-1:0]       dout_re,
  output logic [WIDTH-1:0]       dout_im,
  output logic [IDXW-1:0]        dout_idx,
  output logic                   dout_last
);

  // state | meaning
  // IDLE  | no frame held, ready for a load
  // SHIFT | frame held, slot 0 presented as the current beat
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] re_q [DEPTH];
  logic [WIDTH-1:0] im_q [DEPTH];
  logic [IDXW-1:0]  idx;
  logic             drop_q;
  logic             accept;
  logic             consume;

  function automatic logic [IDXW-1:0] bitrev(input logic [IDXW-1:0] k);
    logic [IDXW-1:0] r;
    for (int i = 0; i < IDXW; i++) r[i] = k[IDXW-1-i];
    return r;
  endfunction

  assign dout_valid = (state == SHIFT);
  assign dout_last  = dout_valid & (idx == IDXW'(DEPTH-1));
  assign consume    = dout_valid & dout_ready;
  assign load_ready = (state == IDLE) | (consume & dout_last);
  assign accept     = load & load_ready;
  assign load_drop  = drop_q;
  assign dout_re    = re_q[0];
  assign dout_im    = im_q[0];
  assign dout_idx   = idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (consume && dout_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A load in the last-beat cycle takes priority over clearing, giving gapless frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        re_q[j] <= '0;
        im_q[j] <= '0;
      end
      idx    <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= load & ~load_ready;
      if (accept) begin
        for (int j = 0; j < DEPTH; j++) begin
          re_q[j] <= din_re[(brev ? int'(bitrev(IDXW'(j))) : j)*WIDTH +: WIDTH];
          im_q[j] <= din_im[(brev ? int'(bitrev(IDXW'(j))) : j)*WIDTH +: WIDTH];
        end
        idx <= '0;
      end else if (consume) begin
        if (dout_last) begin
          for (int j = 0; j < DEPTH; j++) begin
            re_q[j] <= '0;
            im_q[j] <= '0;
          end
          idx <= '0;
        end else begin
          for (int j = 0; j < DEPTH-1; j++) begin
            re_q[j] <= re_q[j+1];
            im_q[j] <= im_q[j+1];
          end
          re_q[DEPTH-1] <= '0;
          im_q[DEPTH-1] <= '0;
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cplx_par2ser_buf.sv
// Directed bench for cplx_par2ser_buf: an 8-lane instance for ordering, stalls,
// back-to-back/drop and mid-frame reset, plus a 64-lane instance for a natural-order frame.
module tb_cplx_par2ser_buf;
  localparam int W  = 10;
  localparam int D  = 8;
  localparam int D2 = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           a_load, a_brev, a_ready;
  logic [D*W-1:0] a_din_re, a_din_im;
  logic           a_load_ready, a_load_drop, a_valid, a_last;
  logic [W-1:0]   a_re, a_im;
  logic [2:0]     a_idx;

  logic            b_load, b_brev, b_ready;
  logic [D2*W-1:0] b_din_re, b_din_im;
  logic            b_load_ready, b_load_drop, b_valid, b_last;
  logic [W-1:0]    b_re, b_im;
  logic [5:0]      b_idx;

  cplx_par2ser_buf #(.WIDTH(W), .DEPTH(D)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(a_load), .brev(a_brev),
    .din_re(a_din_re), .din_im(a_din_im), .load_ready(a_load_ready),
    .load_drop(a_load_drop), .dout_valid(a_valid), .dout_ready(a_ready),
    .dout_re(a_re), .dout_im(a_im), .dout_idx(a_idx), .dout_last(a_last));

  cplx_par2ser_buf #(.WIDTH(W), .DEPTH(D2)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(b_load), .brev(b_brev),
    .din_re(b_din_re), .din_im(b_din_im), .load_ready(b_load_ready),
    .load_drop(b_load_drop), .dout_valid(b_valid), .dout_ready(b_ready),
    .dout_re(b_re), .dout_im(b_im), .dout_idx(b_idx), .dout_last(b_last));

  int n_tests = 0;
  int n_fail  = 0;
  int brt [8] = '{1, 5, 3, 7, 2, 6, 4, 8};

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // lane k: re = re0+k, im = -(im0+k) if neg else im0+k
  task automatic frame_a(input int re0, input int im0, input bit neg);
    for (int k = 0; k < D; k++) begin
      a_din_re[k*W +: W] = W'(re0 + k);
      a_din_im[k*W +: W] = neg ? W'(-(im0 + k)) : W'(im0 + k);
    end
  endtask

  initial begin
    int b;
    rst_n = 1'b0;
    a_load = 1'b1; a_brev = 1'b0; a_ready = 1'b1;
    b_load = 1'b0; b_brev = 1'b0; b_ready = 1'b1;
    frame_a(1, 1, 1'b1);
    b_din_re = '0; b_din_im = '0;

    // reset held with load high
    repeat (3) tick();
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_re", int'(a_re), 0);
    chk("rst_drop", int'(a_load_drop), 0);
    chk("rst_idx", int'(a_idx), 0);
    rst_n = 1'b1; a_load = 1'b0;
    tick();
    chk("post_rst_ready", int'(a_load_ready), 1);
    chk("post_rst_valid", int'(a_valid), 0);

    // natural order
    a_load = 1'b1; a_brev = 1'b0;
    tick();
    a_load = 1'b0;
    for (int k = 0; k < D; k++) begin
      chk("nat_valid", int'(a_valid), 1);
      chk("nat_re", int'(a_re), k + 1);
      chk("nat_im", int'(a_im), 1024 - (k + 1));
      chk("nat_idx", int'(a_idx), k);
      chk("nat_last", int'(a_last), (k == D-1) ? 1 : 0);
      tick();
    end
    chk("nat_end_valid", int'(a_valid), 0);
    chk("nat_end_re", int'(a_re), 0);

    // bit-reversed order
    a_load = 1'b1; a_brev = 1'b1;
    tick();
    a_load = 1'b0; a_brev = 1'b0;
    for (int k = 0; k < D; k++) begin
      chk("brev_re", int'(a_re), brt[k]);
      chk("brev_im", int'(a_im), 1024 - brt[k]);
      chk("brev_idx", int'(a_idx), k);
      tick();
    end
    chk("brev_end_valid", int'(a_valid), 0);

    // stalls: ready pattern 1,0,0,1,0,0,...
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    b = 0;
    for (int cyc = 0; cyc < 40 && b < D; cyc++) begin
      a_ready = (cyc % 3 == 0);
      #1;
      chk("stall_valid", int'(a_valid), 1);
      chk("stall_re", int'(a_re), b + 1);
      chk("stall_idx", int'(a_idx), b);
      if (a_ready) b++;
      tick();
    end
    a_ready = 1'b1;
    chk("stall_beats", b, D);
    chk("stall_end_valid", int'(a_valid), 0);

    // back-to-back A->B with dropped C at A beat 3
    frame_a(1, 1, 1'b1);
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    for (int n = 0; n < 2*D; n++) begin
      chk("b2b_valid", int'(a_valid), 1);
      chk("b2b_re", int'(a_re), (n < D) ? n + 1 : 101 + (n - D));
      chk("b2b_idx", int'(a_idx), n % D);
      chk("b2b_last", int'(a_last), (n % D == D-1) ? 1 : 0);
      chk("b2b_drop", int'(a_load_drop), (n == 4) ? 1 : 0);
      if (n == 3) begin
        frame_a(500, 600, 1'b0);
        a_load = 1'b1;
        #1;
        chk("c_ready", int'(a_load_ready), 0);
      end
      if (n == D-1) begin
        frame_a(101, 201, 1'b0);
        a_load = 1'b1;
        #1;
        chk("b_ready", int'(a_load_ready), 1);
      end
      tick();
      a_load = 1'b0;
    end
    chk("b2b_end_valid", int'(a_valid), 0);
    chk("b2b_end_drop", int'(a_load_drop), 0);

    // mid-frame reset at beat 4
    frame_a(1, 1, 1'b1);
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    repeat (4) tick();
    chk("mid_beat4_re", int'(a_re), 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", int'(a_valid), 0);
    chk("mid_rst_re", int'(a_re), 0);
    chk("mid_rst_ready", int'(a_load_ready), 1);
    repeat (2) tick();
    chk("mid_after_valid", int'(a_valid), 0);
    chk("mid_after_idx", int'(a_idx), 0);

    // 64-lane natural order
    for (int k = 0; k < D2; k++) begin
      b_din_re[k*W +: W] = W'(k + 1);
      b_din_im[k*W +: W] = W'(-(k + 1));
    end
    b_load = 1'b1;
    tick();
    b_load = 1'b0;
    for (int k = 0; k < D2; k++) begin
      chk("d64_re", int'(b_re), k + 1);
      chk("d64_im", int'(b_im), 1024 - (k + 1));
      chk("d64_idx", int'(b_idx), k);
      chk("d64_last", int'(b_last), (k == D2-1) ? 1 : 0);
      tick();
    end
    chk("d64_end_valid", int'(b_valid), 0);
    chk("d64_drop", int'(b_load_drop), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
